// File: rtl/ks_sched_pkg.sv
// Shared types and defaults for the Kogge-Stone add scheduler.
//   state_t : scheduler FSM states
//   req_t   : one request {sub, cin, a, b} at the default operand width
//   idw_of  : index width for n items (minimum 1 bit)
package ks_sched_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_NWORDS = 2;
    localparam int DEF_NREQ   = 4;
    localparam int DEF_OPW    = DEF_WIDTH * DEF_NWORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic               sub;
        logic               cin;
        logic [DEF_OPW-1:0] a;
        logic [DEF_OPW-1:0] b;
    } req_t;

    function automatic int idw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ks_add_scheduler_if.sv
// Request/response bundle between client units and the add scheduler.
//   req_*  : per-requester valid/ready channel, operands packed [i*OPW +: OPW]
//   rsp_*  : single registered response channel with valid/ready
// master = client side, slave = scheduler side.
interface ks_add_scheduler_if
    import ks_sched_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NWORDS = DEF_NWORDS,
    parameter int NREQ   = DEF_NREQ
);
    localparam int OPW = NWORDS * WIDTH;
    localparam int IDW = idw_of(NREQ);

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     req_sub;
    logic [NREQ-1:0]     req_cin;
    logic [NREQ*OPW-1:0] req_a;
    logic [NREQ*OPW-1:0] req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [OPW-1:0]      rsp_sum;
    logic                rsp_cout;
    logic                rsp_ovf;

    modport master (
        output req_valid, req_sub, req_cin, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );

    modport slave (
        input  req_valid, req_sub, req_cin, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );

endinterface

// File: rtl/ks_prefix_adder.sv
// WIDTH-bit Kogge-Stone prefix adder.
//   a, b, cin : addends and carry in
//   sum, cout : result and carry out
module ks_prefix_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // cin is folded in as an extra generate bit below bit 0, so the prefix
    // result at position i is the carry into operand bit i.
    localparam int N   = WIDTH + 1;
    localparam int LVL = $clog2(N);

    logic [N-1:0]     g, p, gn, pn;
    logic [WIDTH-1:0] x;

    always_comb begin
        x = a ^ b;
        g = {a & b, cin};
        p = {x, 1'b0};
        gn = g;
        pn = p;
        for (int l = 0; l < LVL; l++) begin
            gn = g;
            pn = p;
            for (int i = 0; i < N; i++) begin
                if (i >= (1 << l)) begin
                    gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    pn[i] = p[i] & p[i - (1 << l)];
                end
            end
            g = gn;
            p = pn;
        end
        sum  = x ^ g[WIDTH-1:0];
        cout = g[WIDTH];
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   grant     : one-hot grant (zero when no request)
//   grant_idx : index of the granted request
module rr_arbiter
    import ks_sched_pkg::*;
#(
    parameter int  NREQ = DEF_NREQ,
    localparam int IDW  = idw_of(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    int   idx;
    logic found;

    // Scan from ptr upward, wrapping at NREQ; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/ks_add_scheduler.sv
// Shares one prefix adder among NREQ requesters for multi-word add/sub.
// Operands are processed one WIDTH-bit word per cycle, LSW first, with the
// carry chained through a register.
//   clk, rst : clock, async active-high reset
//   bus      : request channels in, registered response channel out
//
// state | meaning
// IDLE  | arbitrate, accept one request and latch its operands
// RUN   | one word per cycle through the adder, k = word index
// RESP  | hold the response until rsp_ready
module ks_add_scheduler
    import ks_sched_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NWORDS = DEF_NWORDS,
    parameter int NREQ   = DEF_NREQ
) (
    input  logic              clk,
    input  logic              rst,
    ks_add_scheduler_if.slave bus
);

    localparam int OPW = NWORDS * WIDTH;
    localparam int IDW = idw_of(NREQ);
    localparam int KW  = idw_of(NWORDS);

    localparam logic [KW-1:0]  KLAST  = KW'(NWORDS - 1);
    localparam logic [IDW-1:0] IDLAST = IDW'(NREQ - 1);

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   id;
    logic [KW-1:0]    k;
    logic             carry;
    logic [OPW-1:0]   a_reg;
    logic [OPW-1:0]   b_reg;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gidx;
    logic             sel_sub;
    logic             sel_cin;
    logic [OPW-1:0]   sel_a;
    logic [OPW-1:0]   sel_b;
    logic [WIDTH-1:0] a_w;
    logic [WIDTH-1:0] b_w;
    logic [WIDTH-1:0] sum_w;
    logic             cout_w;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign bus.req_ready = (state == IDLE) ? grant : '0;
    assign bus.rsp_id    = id;

    assign sel_sub = bus.req_sub[gidx];
    assign sel_cin = bus.req_cin[gidx];
    assign sel_a   = bus.req_a[int'(gidx) * OPW +: OPW];
    assign sel_b   = bus.req_b[int'(gidx) * OPW +: OPW];

    assign a_w = a_reg[int'(k) * WIDTH +: WIDTH];
    assign b_w = b_reg[int'(k) * WIDTH +: WIDTH];

    ks_prefix_adder #(.WIDTH(WIDTH)) u_add (
        .a    (a_w),
        .b    (b_w),
        .cin  (carry),
        .sum  (sum_w),
        .cout (cout_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            id            <= '0;
            k             <= '0;
            carry         <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_cout  <= 1'b0;
            bus.rsp_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        // Subtract is A + ~B + 1; the +1 enters as word-0 carry.
                        a_reg <= sel_a;
                        b_reg <= sel_sub ? ~sel_b : sel_b;
                        carry <= sel_sub | sel_cin;
                        id    <= gidx;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    bus.rsp_sum[int'(k) * WIDTH +: WIDTH] <= sum_w;
                    carry <= cout_w;
                    if (k == KLAST) begin
                        bus.rsp_cout  <= cout_w;
                        bus.rsp_ovf   <= (a_reg[OPW-1] == b_reg[OPW-1]) &&
                                         (sum_w[WIDTH-1] != a_reg[OPW-1]);
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        ptr           <= (id == IDLAST) ? '0 : id + 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ks_add_scheduler.sv
module tb_ks_add_scheduler;
    import ks_sched_pkg::*;

    localparam int WIDTH  = 32;
    localparam int NWORDS = 2;
    localparam int NREQ   = 4;
    localparam int OPW    = WIDTH * NWORDS;
    localparam int TMO    = 50;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ks_add_scheduler_if #(.WIDTH(WIDTH), .NWORDS(NWORDS), .NREQ(NREQ)) bus ();

    ks_add_scheduler #(.WIDTH(WIDTH), .NWORDS(NWORDS), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          r;
        req_t        rq;
        logic [63:0] esum;
        logic        ecout;
        logic        eovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no event within %0d cycles", nm, TMO);
    endtask

    // Reference: plain multi-precision arithmetic on the whole operand.
    function automatic logic [65:0] model(input req_t q);
        logic [63:0]        bb;
        logic               c0;
        logic [64:0]        u;
        logic signed [65:0] sv;
        logic               ovf;
        bb  = q.sub ? ~q.b : q.b;
        c0  = q.sub ? 1'b1 : q.cin;
        u   = {1'b0, q.a} + {1'b0, bb} + {64'd0, c0};
        sv  = $signed({{2{q.a[63]}}, q.a}) + $signed({{2{bb[63]}}, bb}) + $signed({65'd0, c0});
        ovf = (sv[65:63] != 3'b000) && (sv[65:63] != 3'b111);
        return {ovf, u[64], u[63:0]};
    endfunction

    function automatic req_t mkq(input logic s, input logic c, input logic [63:0] a, input logic [63:0] b);
        req_t q;
        q.sub = s; q.cin = c; q.a = a; q.b = b;
        return q;
    endfunction

    function automatic vec_t mk(input int r, input req_t q, input logic [63:0] esum,
                                input logic ec, input logic eo);
        vec_t v;
        v.r = r; v.rq = q; v.esum = esum; v.ecout = ec; v.eovf = eo;
        return v;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic drive_req(input int r, input req_t q);
        bus.req_sub[r]           = q.sub;
        bus.req_cin[r]           = q.cin;
        bus.req_a[r*OPW +: OPW]  = q.a;
        bus.req_b[r*OPW +: OPW]  = q.b;
        bus.req_valid[r]         = 1'b1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_sub   = '0;
        bus.req_cin   = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns granted index or -1.
    task automatic wait_grant(input string nm, output int g);
        int n;
        n = 0;
        #1;
        while (bus.req_ready == '0 && n < TMO) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (bus.req_ready == '0) begin
            timeout(nm);
            g = -1;
        end else begin
            chk({nm, "_onehot"}, 64'($onehot(bus.req_ready)), 64'd1);
            g = idx_of(bus.req_ready);
        end
    endtask

    task automatic wait_rsp(input string nm);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid) timeout(nm);
    endtask

    // Full transaction with rsp_ready held high; lat counts negedges from
    // the grant-visible cycle to the first one showing rsp_valid.
    task automatic run_op(input int r, input req_t q, output int g,
                          output logic [63:0] s, output logic co, output logic ov,
                          output int lat);
        @(negedge clk);
        drive_req(r, q);
        wait_grant("op_grant", g);
        @(negedge clk);
        bus.req_valid[r] = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.rsp_valid) timeout("op_rsp");
        s  = bus.rsp_sum;
        co = bus.rsp_cout;
        ov = bus.rsp_ovf;
        @(negedge clk);
    endtask

    task automatic check_op(input string nm, input int r, input req_t q,
                            input logic [63:0] esum, input logic ec, input logic eo);
        int          g, lat;
        logic [63:0] s;
        logic        co, ov;
        run_op(r, q, g, s, co, ov, lat);
        chk({nm, "_id"},   64'(g), 64'(r));
        chk({nm, "_rspid"}, 64'(bus.rsp_id), 64'(r));
        chk({nm, "_lat"},  64'(lat), 64'(NWORDS + 1));
        chk({nm, "_sum"},  s, esum);
        chk({nm, "_cout"}, 64'(co), 64'(ec));
        chk({nm, "_ovf"},  64'(ov), 64'(eo));
        chk({nm, "_vclr"}, 64'(bus.rsp_valid), 64'd0);
    endtask

    req_t rr_q[NREQ];

    initial begin
        int          g, prev_cyc, n_gr, n_rsp;
        logic [65:0] m;
        logic [63:0] s0;
        req_t        q0, q1, q3, qr;

        do_reset();

        // Reset state
        chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_sum",   bus.rsp_sum, 64'd0);
        chk("rst_id",    64'(bus.rsp_id), 64'd0);
        chk("rst_cout",  64'(bus.rsp_cout), 64'd0);
        chk("rst_ovf",   64'(bus.rsp_ovf), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);

        // Directed vectors, expectations worked by hand
        vecs.push_back(mk(0, mkq(0, 0, 64'h00000000_FFFFFFFF, 64'h1), 64'h00000001_00000000, 0, 0));
        vecs.push_back(mk(2, mkq(1, 0, 64'h5, 64'h7), 64'hFFFFFFFF_FFFFFFFE, 0, 0));
        vecs.push_back(mk(2, mkq(1, 0, 64'h7, 64'h5), 64'h2, 1, 0));
        vecs.push_back(mk(1, mkq(0, 0, 64'h7FFFFFFF_FFFFFFFF, 64'h1), 64'h80000000_00000000, 0, 1));
        vecs.push_back(mk(3, mkq(0, 1, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF), 64'hFFFFFFFF_FFFFFFFF, 1, 0));
        vecs.push_back(mk(1, mkq(1, 0, 64'h80000000_00000000, 64'h1), 64'h7FFFFFFF_FFFFFFFF, 1, 1));
        vecs.push_back(mk(0, mkq(0, 1, 64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321), 64'h22222222_22222212, 0, 0));
        vecs.push_back(mk(3, mkq(1, 1, 64'h0, 64'h0), 64'h0, 1, 0));
        foreach (vecs[i])
            check_op($sformatf("vec%0d", i), vecs[i].r, vecs[i].rq, vecs[i].esum, vecs[i].ecout, vecs[i].eovf);

        // Round-robin with all requesters valid continuously
        do_reset();
        for (int r = 0; r < NREQ; r++) begin
            rr_q[r] = mkq(1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            drive_req(r, rr_q[r]);
        end
        prev_cyc = 0;
        n_gr     = 0;
        n_rsp    = 0;
        for (int cyc = 0; cyc < 60 && n_gr < 5; cyc++) begin
            #1;
            if (bus.req_ready != '0) begin
                chk("rr_onehot", 64'($onehot(bus.req_ready)), 64'd1);
                chk("rr_order", 64'(idx_of(bus.req_ready)), 64'(n_gr % NREQ));
                if (n_gr > 0) chk("rr_spacing", 64'(cyc - prev_cyc), 64'(NWORDS + 2));
                prev_cyc = cyc;
                n_gr++;
            end
            if (bus.rsp_valid) begin
                m = model(rr_q[n_rsp % NREQ]);
                chk("rr_rsp_id", 64'(bus.rsp_id), 64'(n_rsp % NREQ));
                chk("rr_rsp_sum", bus.rsp_sum, m[63:0]);
                chk("rr_rsp_flags", {62'd0, bus.rsp_ovf, bus.rsp_cout}, {62'd0, m[65], m[64]});
                n_rsp++;
            end
            @(negedge clk);
        end
        chk("rr_grants", 64'(n_gr), 64'd5);
        chk("rr_rsps", 64'(n_rsp), 64'd4);

        // Backpressure: response held, pending req1 waits
        do_reset();
        bus.rsp_ready = 1'b0;
        q0 = mkq(0, 0, 64'hDEADBEEF_00000001, 64'h00000001_FFFFFFFF);
        q1 = mkq(1, 0, 64'h00000000_00000010, 64'h00000000_00000003);
        @(negedge clk);
        drive_req(0, q0);
        wait_grant("bp_grant0", g);
        chk("bp_grant0_id", 64'(g), 64'd0);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        drive_req(1, q1);
        wait_rsp("bp_rsp0");
        s0 = bus.rsp_sum;
        m  = model(q0);
        chk("bp_sum0", s0, m[63:0]);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", 64'(bus.rsp_valid), 64'd1);
            chk("bp_sum_hold", bus.rsp_sum, s0);
            chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_hs_no_grant", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("bp_req1_grant", 64'(bus.req_ready), 64'b0010);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        wait_rsp("bp_rsp1");
        m = model(q1);
        chk("bp_id1", 64'(bus.rsp_id), 64'd1);
        chk("bp_sum1", bus.rsp_sum, m[63:0]);
        @(negedge clk);

        // Reset in the middle of RUN
        do_reset();
        check_op("pre_rst", 2, mkq(0, 0, 64'h3, 64'h4), 64'h7, 0, 0);
        q3 = mkq(0, 0, 64'h11111111_22222222, 64'h1);
        @(negedge clk);
        drive_req(3, q3);
        wait_grant("mr_grant3", g);
        chk("mr_grant3_id", 64'(g), 64'd3);
        @(negedge clk);
        bus.req_valid[3] = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mr_sum", bus.rsp_sum, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q0 = mkq(0, 1, 64'h00000001_80000000, 64'h00000002_80000000);
        drive_req(0, q0);
        drive_req(3, q3);
        wait_grant("mr_after", g);
        chk("mr_ptr_zero", 64'(g), 64'd0);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        wait_rsp("mr_rsp0");
        chk("mr_sum0", bus.rsp_sum, 64'h00000004_00000001);
        chk("mr_id0", 64'(bus.rsp_id), 64'd0);
        @(negedge clk);
        wait_grant("mr_next", g);
        chk("mr_next_id", 64'(g), 64'd3);
        @(negedge clk);
        bus.req_valid[3] = 1'b0;
        wait_rsp("mr_rsp3");
        chk("mr_sum3", bus.rsp_sum, 64'h11111111_22222223);
        @(negedge clk);

        // Randomized ops against the arithmetic model
        for (int t = 0; t < 40; t++) begin
            int          r, lat;
            logic [63:0] s, a, b;
            logic        co, ov;
            r = int'($urandom_range(0, NREQ - 1));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: a = {1'b0, {63{1'b1}}};
                1: b = '1;
                2: a[31:0] = '1;
                default: ;
            endcase
            qr = mkq(1'($urandom), 1'($urandom), a, b);
            m  = model(qr);
            run_op(r, qr, g, s, co, ov, lat);
            chk("rnd_id", 64'(g), 64'(r));
            chk("rnd_sum", s, m[63:0]);
            chk("rnd_flags", {62'd0, ov, co}, {62'd0, m[65], m[64]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
